// File: rtl/checkpoint_alloc_ctrl_pkg.sv
// Shared sizing and pointer types for the rename checkpoint allocator.
// Consumed by checkpoint_alloc_ctrl and by the checkpoint array itself.
package checkpoint_alloc_ctrl_pkg;

   localparam int CHECKPOINT_COUNT     = 8;
   localparam int LOG_CHECKPOINT_COUNT = $clog2(CHECKPOINT_COUNT);
   localparam int CHECKPOINT_THRESHOLD = 3;

   typedef logic [LOG_CHECKPOINT_COUNT-1:0] CHECKPOINT_idx_t;

   // Wrap bit above the slot index, so that full and empty can be told apart.
   typedef logic [LOG_CHECKPOINT_COUNT:0]   CHECKPOINT_ptr_t;

endpackage

// File: rtl/checkpoint_alloc_ctrl.sv
// Circular allocator for rename checkpoints: in-order save, oldest-first commit,
// and restore that frees a slot plus everything younger. Optional perf counters
// are built only when CHECKPOINT_ALLOC_PERF_EN is defined.
module checkpoint_alloc_ctrl
   import checkpoint_alloc_ctrl_pkg::*;
#(
   parameter int  CHECKPOINT_COUNT     = checkpoint_alloc_ctrl_pkg::CHECKPOINT_COUNT,
   parameter int  CHECKPOINT_THRESHOLD = checkpoint_alloc_ctrl_pkg::CHECKPOINT_THRESHOLD,
   localparam int LOG_CHECKPOINT_COUNT = $clog2(CHECKPOINT_COUNT)
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            save_valid,
   input  logic                            save_low_prio,
   output logic                            save_ready,
   output logic [LOG_CHECKPOINT_COUNT-1:0] save_idx,
   input  logic                            commit_valid,
   input  logic                            restore_valid,
   input  logic [LOG_CHECKPOINT_COUNT-1:0] restore_idx,
   output logic [CHECKPOINT_COUNT-1:0]     occupied_vec,
   output logic [LOG_CHECKPOINT_COUNT:0]   free_count,
   output logic                            empty,
   output logic                            full,
   output logic                            restore_err,
   output logic [31:0]                     perf_save_stall_cycles,
   output logic [31:0]                     perf_restore_count
);

   typedef logic [LOG_CHECKPOINT_COUNT-1:0] idx_t;
   typedef logic [LOG_CHECKPOINT_COUNT:0]   ptr_t;

   localparam ptr_t COUNT_P     = ptr_t'(CHECKPOINT_COUNT);
   localparam ptr_t THRESHOLD_P = ptr_t'(CHECKPOINT_THRESHOLD);

   ptr_t head_q, head_d;
   ptr_t tail_q, tail_d;
   logic restore_err_q, restore_err_d;

   idx_t head_idx;
   logic head_wrap;
   ptr_t used;
   ptr_t restore_tail;
   idx_t slot_offset;
   logic save_fire;
   logic commit_ok;
   logic restore_ok;

   always_comb begin
      head_idx   = head_q[LOG_CHECKPOINT_COUNT-1:0];
      head_wrap  = head_q[LOG_CHECKPOINT_COUNT];
      used       = tail_q - head_q;
      free_count = COUNT_P - used;
      empty      = (head_q == tail_q);
      full       = (head_idx == tail_q[LOG_CHECKPOINT_COUNT-1:0]) &&
                   (head_wrap != tail_q[LOG_CHECKPOINT_COUNT]);
      save_idx   = tail_q[LOG_CHECKPOINT_COUNT-1:0];

      // A slot is live when its distance from head falls inside the used span.
      occupied_vec = '0;
      slot_offset  = '0;
      for (int i = 0; i < CHECKPOINT_COUNT; i++) begin
         slot_offset     = idx_t'(i) - head_idx;
         occupied_vec[i] = ({1'b0, slot_offset} < used);
      end

      save_ready = !RST && !restore_valid && !full &&
                   (!save_low_prio || (free_count > THRESHOLD_P));
      save_fire  = save_valid && save_ready;
      commit_ok  = commit_valid && !empty;
      restore_ok = restore_valid && occupied_vec[restore_idx];

      // An index below head belongs to the lap after head's.
      restore_tail = {((restore_idx >= head_idx) ? head_wrap : !head_wrap), restore_idx};
   end

   always_comb begin
      head_d        = head_q;
      tail_d        = tail_q;
      restore_err_d = restore_err_q;

      if (commit_ok) begin
         head_d = head_q + ptr_t'(1);
      end
      if (save_fire) begin
         tail_d = tail_q + ptr_t'(1);
      end
      if (restore_ok) begin
         tail_d = restore_tail;
         if (commit_ok && (restore_idx == head_idx)) begin
            head_d = restore_tail;
         end
      end

      if ((commit_valid && empty) || (restore_valid && !occupied_vec[restore_idx])) begin
         restore_err_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         head_q        <= '0;
         tail_q        <= '0;
         restore_err_q <= 1'b0;
      end else begin
         head_q        <= head_d;
         tail_q        <= tail_d;
         restore_err_q <= restore_err_d;
      end
   end

   assign restore_err = restore_err_q;

`ifdef CHECKPOINT_ALLOC_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_restore_q, perf_restore_d;

   // Both counters saturate instead of wrapping.
   always_comb begin
      perf_stall_d   = perf_stall_q;
      perf_restore_d = perf_restore_q;
      if (save_valid && !save_ready && (perf_stall_q != '1)) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
      if (restore_ok && (perf_restore_q != '1)) begin
         perf_restore_d = perf_restore_q + 32'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         perf_stall_q   <= '0;
         perf_restore_q <= '0;
      end else begin
         perf_stall_q   <= perf_stall_d;
         perf_restore_q <= perf_restore_d;
      end
   end

   assign perf_save_stall_cycles = perf_stall_q;
   assign perf_restore_count     = perf_restore_q;
`else
   assign perf_save_stall_cycles = '0;
   assign perf_restore_count     = '0;
`endif

endmodule

// File: tb/tb_checkpoint_alloc_ctrl.sv
// Self-checking bench for checkpoint_alloc_ctrl: directed scenarios plus random
// traffic, compared each cycle against a queue-based model of live checkpoints.
module tb_checkpoint_alloc_ctrl;

   localparam int N   = 8;
   localparam int THR = 3;

   logic        CLK;
   logic        RST;
   logic        save_valid;
   logic        save_low_prio;
   logic        save_ready;
   logic [2:0]  save_idx;
   logic        commit_valid;
   logic        restore_valid;
   logic [2:0]  restore_idx;
   logic [7:0]  occupied_vec;
   logic [3:0]  free_count;
   logic        empty;
   logic        full;
   logic        restore_err;
   logic [31:0] perf_save_stall_cycles;
   logic [31:0] perf_restore_count;

   checkpoint_alloc_ctrl dut (
      .CLK                    (CLK),
      .RST                    (RST),
      .save_valid             (save_valid),
      .save_low_prio          (save_low_prio),
      .save_ready             (save_ready),
      .save_idx               (save_idx),
      .commit_valid           (commit_valid),
      .restore_valid          (restore_valid),
      .restore_idx            (restore_idx),
      .occupied_vec           (occupied_vec),
      .free_count             (free_count),
      .empty                  (empty),
      .full                   (full),
      .restore_err            (restore_err),
      .perf_save_stall_cycles (perf_save_stall_cycles),
      .perf_restore_count     (perf_restore_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Model state: live slot indices oldest-first, next slot to hand out.
   int          mq[$];
   int          mtail;
   bit          merr;
   int unsigned mstall;
   int unsigned mrestores;

   function automatic bit modelReady();
      return !RST && !restore_valid && (mq.size() < N) &&
             (!save_low_prio || ((N - mq.size()) > THR));
   endfunction

   function automatic int modelPos(int idx);
      for (int k = 0; k < mq.size(); k++) begin
         if (mq[k] == idx) return k;
      end
      return -1;
   endfunction

   function automatic logic [7:0] modelOcc();
      logic [7:0] m;
      m = '0;
      foreach (mq[k]) m[mq[k]] = 1'b1;
      return m;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit sv, input bit lp,
                                input bit cv, input bit rv, input int ridx);
      RST           = rst;
      save_valid    = sv;
      save_low_prio = lp;
      commit_valid  = cv;
      restore_valid = rv;
      restore_idx   = 3'(ridx);
   endtask

   task automatic checkOutput();
      cmp("save_ready", 32'(save_ready), 32'(modelReady()));
      cmp("save_idx", 32'(save_idx), 32'(mtail));
      cmp("occupied_vec", 32'(occupied_vec), 32'(modelOcc()));
      cmp("free_count", 32'(free_count), 32'(N - mq.size()));
      cmp("empty", 32'(empty), 32'(mq.size() == 0));
      cmp("full", 32'(full), 32'(mq.size() == N));
      cmp("restore_err", 32'(restore_err), 32'(merr));
`ifdef CHECKPOINT_ALLOC_PERF_EN
      cmp("perf_stall", perf_save_stall_cycles, mstall);
      cmp("perf_restore", perf_restore_count, mrestores);
`else
      cmp("perf_stall", perf_save_stall_cycles, 32'd0);
      cmp("perf_restore", perf_restore_count, 32'd0);
`endif
   endtask

   // Applies the rules to the inputs that were present at the clock edge.
   task automatic modelUpdate();
      bit fire;
      bit commitOk;
      int pos;
      if (RST) begin
         mq.delete();
         mtail     = 0;
         merr      = 0;
         mstall    = 0;
         mrestores = 0;
         return;
      end
      fire     = save_valid && modelReady();
      commitOk = commit_valid && (mq.size() > 0);
      pos      = restore_valid ? modelPos(int'(restore_idx)) : -1;
      if (save_valid && !fire && mstall != 32'hFFFF_FFFF) mstall++;
      if (commit_valid && mq.size() == 0) merr = 1;
      if (restore_valid && pos < 0) merr = 1;
      if (pos >= 0) begin
         while (mq.size() > pos) void'(mq.pop_back());
         mtail = int'(restore_idx);
         if (mrestores != 32'hFFFF_FFFF) mrestores++;
      end
      if (commitOk && mq.size() > 0) void'(mq.pop_front());
      if (fire) begin
         mq.push_back(mtail);
         mtail = (mtail + 1) % N;
      end
   endtask

   task automatic doCycle(input bit rst, input bit sv, input bit lp,
                          input bit cv, input bit rv, input int ridx);
      applyStimulus(rst, sv, lp, cv, rv, ridx);
      #2;
      checkOutput();
      @(posedge CLK);
      modelUpdate();
      #1;
   endtask

   task automatic resetCycle();
      doCycle(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int ridx;
      applyStimulus(1, 0, 0, 0, 0, 0);
      @(posedge CLK);
      modelUpdate();
      #1;

      // Eight high-priority saves fill the array.
      for (int i = 0; i < N; i++) doCycle(0, 1, 0, 0, 0, 0);
      cmp("fill_full", 32'(full), 32'd1);
      cmp("fill_free", 32'(free_count), 32'd0);
      cmp("fill_ready", 32'(save_ready), 32'd0);
      doCycle(0, 1, 0, 0, 0, 0);

      // Low-priority saves stop once only THR slots remain; high priority still goes.
      resetCycle();
      for (int i = 0; i < 6; i++) doCycle(0, 1, 1, 0, 0, 0);
      cmp("throttle_free", 32'(free_count), 32'd3);
      cmp("throttle_ready", 32'(save_ready), 32'd0);
      doCycle(0, 1, 0, 0, 0, 0);
      cmp("hiprio_free", 32'(free_count), 32'd2);

      // Restore into the middle of the live span.
      resetCycle();
      for (int i = 0; i < 6; i++) doCycle(0, 1, 0, 0, 0, 0);
      doCycle(0, 0, 0, 0, 1, 2);
      cmp("mid_occ", 32'(occupied_vec), 32'h03);
      cmp("mid_idx", 32'(save_idx), 32'd2);
      doCycle(0, 0, 0, 0, 0, 0);

      // Restore after the tail has wrapped.
      resetCycle();
      for (int i = 0; i < 8; i++) doCycle(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) doCycle(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) doCycle(0, 1, 0, 0, 0, 0);
      doCycle(0, 0, 0, 0, 1, 1);
      cmp("wrap_occ", 32'(occupied_vec), 32'hC1);
      cmp("wrap_free", 32'(free_count), 32'd5);
      doCycle(0, 1, 0, 1, 0, 0);

      // Commit together with restore of the head empties everything.
      resetCycle();
      for (int i = 0; i < 3; i++) doCycle(0, 1, 0, 0, 0, 0);
      doCycle(0, 1, 0, 1, 1, 0);
      cmp("clamp_empty", 32'(empty), 32'd1);
      cmp("clamp_free", 32'(free_count), 32'd8);
      cmp("clamp_idx", 32'(save_idx), 32'd0);
      doCycle(0, 0, 0, 0, 0, 0);

      // Restore of an unallocated slot is ignored and sticks in restore_err.
      resetCycle();
      doCycle(0, 0, 0, 0, 1, 5);
      cmp("err_set", 32'(restore_err), 32'd1);
      cmp("err_empty", 32'(empty), 32'd1);
      for (int i = 0; i < 3; i++) doCycle(0, 1, 0, 0, 1, 0);
      cmp("err_sticky", 32'(restore_err), 32'd1);

      // Random traffic, restores biased toward live slots.
      resetCycle();
      for (int c = 0; c < 500; c++) begin
         ridx = int'($urandom_range(0, N - 1));
         if (mq.size() > 0 && $urandom_range(0, 1) == 1)
            ridx = mq[$urandom_range(0, mq.size() - 1)];
         doCycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1) == 1, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0), ridx);
      end

      resetCycle();
      cmp("final_err_clear", 32'(restore_err), 32'd0);
      cmp("final_empty", 32'(empty), 32'd1);
      doCycle(0, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
